// File: rtl/modulo_pkg.sv
// Shared constants for the round-robin modulo scheduler: widths and FSM state encoding.
package modulo_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NREQ  = 2;
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned ID_W  = 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/modulo_rr_scheduler_if.sv
// Requester and result handshake bundle for the modulo scheduler.
interface modulo_rr_scheduler_if;
    import modulo_pkg::*;

    logic [NREQ-1:0]  req_valid_i;
    logic [NREQ-1:0]  req_ready_o;
    logic [WIDTH-1:0] req0_data0_i;
    logic [WIDTH-1:0] req0_data1_i;
    logic [WIDTH-1:0] req1_data0_i;
    logic [WIDTH-1:0] req1_data1_i;
    logic             result_valid_o;
    logic             result_ready_i;
    logic [WIDTH-1:0] result_o;
    logic [ID_W-1:0]  result_id_o;
    logic             dbz_o;
    logic             busy_o;

    modport slave (
        input  req_valid_i, req0_data0_i, req0_data1_i, req1_data0_i, req1_data1_i,
        input  result_ready_i,
        output req_ready_o, result_valid_o, result_o, result_id_o, dbz_o, busy_o
    );

    modport master (
        output req_valid_i, req0_data0_i, req0_data1_i, req1_data0_i, req1_data1_i,
        output result_ready_i,
        input  req_ready_o, result_valid_o, result_o, result_id_o, dbz_o, busy_o
    );

endinterface

// File: rtl/modulo_seq_core.sv
// Restoring shift-subtract remainder engine: one quotient bit per cycle, WIDTH cycles per job.
module modulo_seq_core
    import modulo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done_c,
    output logic [WIDTH-1:0] rem_c
);

    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [CNT_W-1:0] cnt;
    logic             running;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // The shifted remainder needs WIDTH+1 bits; the borrow of the trial subtract decides restore.
    always_comb begin
        rem_sh = {rem, dvd[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs};
        rem_c  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        done_c = running && (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd     <= '0;
            dvs     <= '0;
            rem     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            dvd     <= dividend;
            dvs     <= divisor;
            rem     <= '0;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            rem     <= rem_c;
            dvd     <= {dvd[WIDTH-2:0], 1'b0};
            cnt     <= cnt + CNT_W'(1);
            running <= !done_c;
        end
    end

endmodule

// File: rtl/modulo_rr_scheduler.sv
// Two-requester round-robin front end, job FSM and result registers around the shared remainder core.
module modulo_rr_scheduler
    import modulo_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    modulo_rr_scheduler_if.slave bus
);

    logic [1:0]       state, state_d;
    logic             rr_ptr, rr_ptr_d;
    logic [NREQ-1:0]  grant_c;
    logic             accept_c;
    logic             gid_c;
    logic [WIDTH-1:0] sel_dividend_c;
    logic [WIDTH-1:0] sel_divisor_c;
    logic             start_c;
    logic             core_done_c;
    logic [WIDTH-1:0] core_rem_c;
    logic             valid_d;
    logic [WIDTH-1:0] result_d;
    logic [ID_W-1:0]  id_d;
    logic             dbz_d;

    // Grant only in IDLE; on contention rr_ptr picks the winner.
    always_comb begin
        grant_c = '0;
        if (state == ST_IDLE) begin
            if (bus.req_valid_i == 2'b11) grant_c[rr_ptr] = 1'b1;
            else                          grant_c = bus.req_valid_i;
        end
    end

    assign bus.req_ready_o = grant_c;
    assign accept_c        = |grant_c;
    assign gid_c           = grant_c[1];
    assign sel_dividend_c  = gid_c ? bus.req1_data0_i : bus.req0_data0_i;
    assign sel_divisor_c   = gid_c ? bus.req1_data1_i : bus.req0_data1_i;

    modulo_seq_core u_core (
        .clk      (clk_i),
        .rst      (rst_i),
        .start    (start_c),
        .dividend (sel_dividend_c),
        .divisor  (sel_divisor_c),
        .done_c   (core_done_c),
        .rem_c    (core_rem_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state;
        rr_ptr_d = rr_ptr;
        valid_d  = bus.result_valid_o;
        result_d = bus.result_o;
        id_d     = bus.result_id_o;
        dbz_d    = bus.dbz_o;
        start_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    rr_ptr_d = !gid_c;
                    id_d     = ID_W'(gid_c);
                    if (sel_divisor_c == '0) begin
                        state_d  = ST_DONE;
                        valid_d  = 1'b1;
                        result_d = '0;
                        dbz_d    = 1'b1;
                    end else begin
                        state_d  = ST_CALC;
                        start_c  = 1'b1;
                        dbz_d    = 1'b0;
                    end
                end
            end
            ST_CALC: begin
                if (core_done_c) begin
                    state_d  = ST_DONE;
                    valid_d  = 1'b1;
                    result_d = core_rem_c;
                end
            end
            ST_DONE: begin
                if (bus.result_ready_i) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state              <= ST_IDLE;
            rr_ptr             <= 1'b0;
            bus.result_valid_o <= 1'b0;
            bus.result_o       <= '0;
            bus.result_id_o    <= '0;
            bus.dbz_o          <= 1'b0;
            bus.busy_o         <= 1'b0;
        end else begin
            state              <= state_d;
            rr_ptr             <= rr_ptr_d;
            bus.result_valid_o <= valid_d;
            bus.result_o       <= result_d;
            bus.result_id_o    <= id_d;
            bus.dbz_o          <= dbz_d;
            bus.busy_o         <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_modulo_rr_scheduler.sv
// Scoreboard bench for modulo_rr_scheduler: directed jobs push expectations, a monitor checks results.
module tb_modulo_rr_scheduler;
    import modulo_pkg::*;

    typedef struct packed {
        logic       id;
        logic [7:0] res;
        logic       dbz;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    modulo_rr_scheduler_if bus ();

    modulo_rr_scheduler dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every result handshake pops one expectation.
    always @(negedge clk) begin
        if (!rst && bus.result_valid_o && bus.result_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=%0d expected=none", bus.result_o);
            end else begin
                mon_e = sb.pop_front();
                chk("result_id", int'(bus.result_id_o), int'(mon_e.id));
                chk("result_val", int'(bus.result_o), int'(mon_e.res));
                chk("result_dbz", int'(bus.dbz_o), int'(mon_e.dbz));
            end
        end
    end

    // Raise valid, wait for grant, push expectation, drop valid just after the accept edge.
    task automatic request(input int id, input int a, input int b,
                           input int er, input int edbz, input bit push);
        bit ok = 1'b0;
        if (id == 0) begin
            bus.req0_data0_i = 8'(a);
            bus.req0_data1_i = 8'(b);
        end else begin
            bus.req1_data0_i = 8'(a);
            bus.req1_data1_i = 8'(b);
        end
        bus.req_valid_i[id] = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (bus.req_ready_o[id]) ok = 1'b1;
        end
        if (!ok) chk("grant_timeout", 0, 1);
        else if (push) sb.push_back('{id: 1'(id), res: 8'(er), dbz: 1'(edbz)});
        tick();
        bus.req_valid_i[id] = 1'b0;
    endtask

    // Counts edges from the accept edge (inclusive) to the first cycle result_valid_o is high.
    task automatic wait_result(input int exp_lat);
        int lat = 1;
        while (!bus.result_valid_o && lat < 100) begin
            tick();
            lat++;
        end
        chk("latency", lat, exp_lat);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy_o && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("idle_timeout", 0, 1);
        tick();
    endtask

    initial begin
        int a0[4] = '{100, 101, 102, 103};
        int r0[4] = '{2, 3, 4, 5};
        int a1[4] = '{60, 61, 62, 63};
        int r1[4] = '{5, 6, 7, 8};
        int k0 = 0;
        int k1 = 0;
        int g = 0;
        int accepted = 0;
        bit saw_valid = 1'b0;

        bus.req_valid_i    = '0;
        bus.req0_data0_i   = '0;
        bus.req0_data1_i   = '0;
        bus.req1_data0_i   = '0;
        bus.req1_data1_i   = '0;
        bus.result_ready_i = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_valid", int'(bus.result_valid_o), 0);
        chk("rst_result", int'(bus.result_o), 0);
        chk("rst_id", int'(bus.result_id_o), 0);
        chk("rst_dbz", int'(bus.dbz_o), 0);
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_ready", int'(bus.req_ready_o), 0);
        rst = 1'b0;
        tick();

        // Single job and edge values
        request(0, 200, 7, 4, 0, 1'b1);   wait_result(9); wait_idle();
        request(1, 255, 16, 15, 0, 1'b1); wait_result(9); wait_idle();
        request(1, 5, 9, 5, 0, 1'b1);     wait_result(9); wait_idle();
        request(1, 255, 1, 0, 0, 1'b1);   wait_result(9); wait_idle();
        request(0, 13, 0, 0, 1, 1'b1);    wait_result(1); wait_idle();

        // Contention from a fresh reset: grants must alternate starting at 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req0_data0_i = 8'(a0[0]);
        bus.req0_data1_i = 8'd7;
        bus.req1_data0_i = 8'(a1[0]);
        bus.req1_data1_i = 8'd11;
        bus.req_valid_i  = 2'b11;
        for (int n = 0; n < 400 && accepted < 8; n++) begin
            @(negedge clk);
            if (bus.req_ready_o != 2'b00) begin
                chk("rr_grant", int'(bus.req_ready_o), 1 << g);
                if (g == 0) sb.push_back('{id: 1'b0, res: 8'(r0[k0 % 4]), dbz: 1'b0});
                else        sb.push_back('{id: 1'b1, res: 8'(r1[k1 % 4]), dbz: 1'b0});
                tick();
                if (g == 0) begin
                    k0++;
                    if (k0 < 4) bus.req0_data0_i = 8'(a0[k0]);
                    else        bus.req_valid_i[0] = 1'b0;
                end else begin
                    k1++;
                    if (k1 < 4) bus.req1_data0_i = 8'(a1[k1]);
                    else        bus.req_valid_i[1] = 1'b0;
                end
                g ^= 1;
                accepted++;
            end
        end
        chk("rr_jobs", accepted, 8);
        bus.req_valid_i = 2'b00;
        wait_idle();

        // Backpressure: result held in DONE, no grants while pending
        bus.result_ready_i = 1'b0;
        request(0, 77, 10, 7, 0, 1'b1);
        wait_result(9);
        bus.req0_data0_i = 8'd9;
        bus.req0_data1_i = 8'd4;
        bus.req_valid_i  = 2'b11;
        for (int n = 0; n < 20; n++) begin
            tick();
            chk("bp_result", int'(bus.result_o), 7);
            chk("bp_ready", int'(bus.req_ready_o), 0);
            chk("bp_state", int'({bus.result_valid_o, bus.busy_o, bus.result_id_o, bus.dbz_o}), 12);
        end
        bus.req_valid_i    = 2'b00;
        bus.result_ready_i = 1'b1;
        wait_idle();

        // Reset during iteration 4 of a requester-1 job
        request(1, 200, 3, 0, 0, 1'b0);
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        chk("amid_valid", int'(bus.result_valid_o), 0);
        chk("amid_result", int'(bus.result_o), 0);
        chk("amid_id", int'(bus.result_id_o), 0);
        chk("amid_busy", int'(bus.busy_o), 0);
        tick();
        tick();
        rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (bus.result_valid_o) saw_valid = 1'b1;
        end
        chk("no_stale_result", int'(saw_valid), 0);
        request(0, 100, 30, 10, 0, 1'b1);
        wait_result(9);
        wait_idle();

        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/modulo_rr_scheduler.md
Name: modulo_rr_scheduler

Overview:
- Shares one multi-cycle 8-bit remainder engine between two requesters using round-robin arbitration.
- Each requester presents a dividend/divisor pair with a valid/ready handshake.
- The block serialises the jobs, computes data0 mod data1 by restoring shift-subtract over 8 iterations, and returns the result with the requester ID, a divide-by-zero flag and output backpressure.
- Sits between ALU operand sources and the ALU result mux as the sequential replacement for the combinational modulo path.

Parameters:
- WIDTH, 8, operand and result width in bits; all counts below are for WIDTH=8.
- NREQ, 2, number of requesters; fixed at 2 in this revision.

Ports:
- clk_i  input  1  single clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- req_valid_i  input  NREQ  per-requester operand valid.
- req_ready_o  output  NREQ  per-requester accept; one-hot or zero.
- req0_data0_i  input  WIDTH  requester 0 dividend.
- req0_data1_i  input  WIDTH  requester 0 divisor.
- req1_data0_i  input  WIDTH  requester 1 dividend.
- req1_data1_i  input  WIDTH  requester 1 divisor.
- result_valid_o  output  1  result available.
- result_ready_i  input  1  consumer accepts result.
- result_o  output  WIDTH  remainder.
- result_id_o  output  1  requester index that owns result_o.
- dbz_o  output  1  divisor was zero.
- busy_o  output  1  high in every state except IDLE.

Behaviour:
- Reset values: state=IDLE; rr_ptr=0; req_ready_o=0; result_valid_o=0; result_o=0; result_id_o=0; dbz_o=0; busy_o=0. Reset asserted mid-job aborts the job; no result is ever emitted for it.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - req_ready_o is combinational from req_valid_i and rr_ptr.
  - Only one valid: grant that requester.
  - Both valid: grant requester rr_ptr.
  - No valid: req_ready_o=0.
  - Accept = valid & ready at a rising edge. On accept, latch dividend, divisor and ID.
  - On accept, rr_ptr becomes the index that was not granted, so rr_ptr toggles only on an actual grant.
  - On accept with divisor != 0: go to CALC, iter_cnt=0, partial remainder=0.
  - On accept with divisor == 0: go directly to DONE with result_o=0 and dbz_o=1.
- CALC:
  - Each cycle: rem = {rem[WIDTH-2:0], dividend[MSB]}; shift dividend left; if rem >= divisor, rem = rem - divisor.
  - The comparison uses WIDTH+1 bits so a shifted-in value of 255 is not lost.
  - Runs exactly WIDTH cycles. Transition to DONE when iter_cnt==WIDTH-1.
  - req_ready_o=0 throughout.
- DONE:
  - result_valid_o=1; result_o, result_id_o and dbz_o are registered and held stable until the handshake.
  - On result_valid_o & result_ready_i: go to IDLE and clear result_valid_o. No new request is accepted in the same cycle as the result handshake.
- Latency, counted from the accept edge to the first cycle result_valid_o is high:
  - Normal job: WIDTH+1 edges, i.e. 9.
  - Divide-by-zero job: 1 edge.
- Throughput: one job per WIDTH+2 cycles minimum (one IDLE cycle for arbitration).
- Requester inputs must stay stable while valid is high and ready is low. The block does not register unaccepted requests.
- Dividend < divisor: result = dividend.
- Divisor = 1: result = 0.
- Dividend = 0: result = 0.
- busy_o = (state != IDLE).

Decomposition:
- Shared package modulo_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2;
  - iteration-count width constant;
  - requester-ID width constant.
- Natural sub-module: modulo_seq_core. It contains the restoring shift-subtract datapath and iteration counter, with start/done strobes and the latched operands.
- The top level keeps the arbiter, the FSM and the output registers.

Test Plan:
- Single job: req 0 sends 200 mod 7 and the consumer is always ready -> result_o=4, result_id_o=0, dbz_o=0, result_valid_o asserted 9 cycles after accept.
- Edge values: back-to-back jobs on requester 1 of 255 mod 16, 5 mod 9 and 255 mod 1 -> results 15, 5 and 0; each accepted only after the previous result handshake.
- Divide by zero: req 0 sends 13 mod 0 -> result_valid_o one cycle after accept, result_o=0, dbz_o=1.
- Contention: both requesters valid continuously from reset -> grants alternate 0,1,0,1; result_id_o sequence matches; no starvation over 8 jobs.
- Backpressure: result_ready_i held low for 20 cycles in DONE -> result_o, result_id_o and dbz_o stable; req_ready_o=0; state stays DONE until ready rises.
- Reset mid-operation: assert rst_i asynchronously during CALC iteration 4 -> all outputs at reset values immediately; no stale result after release; the next job 100 mod 30 returns 10.
